// File: rtl/onewire_master.sv
`timescale 1ns/1ps
// onewire_master: standard-speed 1-wire reset/bit/byte timing engine for two open-drain buses
// Ports: clock29M/reset (async, active-high); cmdValid/cmdType/cmdData/busSelect command in;
// busIn raw pad levels; pullLow per-bus drive-low; busy/done/presence/rxData status out.
module onewire_master #(
  parameter int unsigned US_DIVIDER   = 30,
  parameter int unsigned RESET_LOW_US = 480,
  parameter int unsigned PRESENCE_US  = 550,
  parameter int unsigned RESET_END_US = 960,
  parameter int unsigned SLOT_US      = 70,
  parameter int unsigned SAMPLE_US    = 15
) (
  input  logic       clock29M,
  input  logic       reset,
  input  logic       cmdValid,
  input  logic [1:0] cmdType,
  input  logic [7:0] cmdData,
  input  logic       busSelect,
  input  logic [1:0] busIn,
  output logic [1:0] pullLow,
  output logic       busy,
  output logic       done,
  output logic       presence,
  output logic [7:0] rxData
);
  localparam int PW = (US_DIVIDER > 1) ? $clog2(US_DIVIDER) : 1;
  localparam int UW = $clog2(RESET_END_US + 1);
  localparam logic [PW-1:0] L_PRE_MAX   = PW'(US_DIVIDER - 1);
  localparam logic [UW-1:0] L_RST_LOW   = UW'(RESET_LOW_US);
  localparam logic [UW-1:0] L_PRES      = UW'(PRESENCE_US);
  localparam logic [UW-1:0] L_RST_END   = UW'(RESET_END_US);
  localparam logic [UW-1:0] L_SLOT_LAST = UW'(SLOT_US - 1);
  localparam logic [UW-1:0] L_SAMPLE    = UW'(SAMPLE_US);
  localparam logic [UW-1:0] L_LOW1      = UW'(6);
  localparam logic [UW-1:0] L_LOW0      = UW'(60);
  typedef enum logic [1:0] {IDLE, RST, SLOT, FINISH} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync1, r_sync2;
  logic [PW-1:0] r_pre;
  logic [UW-1:0] r_us;
  logic r_bus, r_byte, r_presence;
  logic [7:0] r_tx, r_rx, r_rxdata;
  logic [2:0] r_cnt;
  logic w_accept, w_tick, w_bus_s, w_slot_end, w_last, w_low;
  // acceptance is decoded from the state register, not from busy, to keep the FSM loop-free
  assign w_accept   = cmdValid && (r_state == IDLE || r_state == FINISH) && cmdType != 2'd3;
  assign w_tick     = r_pre == L_PRE_MAX;
  assign w_bus_s    = r_sync2[r_bus];
  // the slot counter runs 0..SLOT_US-1, so the wrap lands exactly SLOT_US ticks after slot start
  assign w_slot_end = r_state == SLOT && w_tick && r_us == L_SLOT_LAST;
  assign w_last     = w_slot_end && (!r_byte || r_cnt == 3'd7);
  assign pullLow    = {r_bus & w_low, ~r_bus & w_low};
  assign presence   = r_presence;
  assign rxData     = r_rxdata;
  always_ff @(posedge clock29M or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    w_low  = 1'b0;
    case (r_state)
      IDLE, FINISH: begin
        done   = r_state == FINISH;
        w_next = w_accept ? (cmdType == 2'd0 ? RST : SLOT) : IDLE;
      end
      RST: begin
        busy   = 1'b1;
        w_low  = r_us < L_RST_LOW;
        w_next = (w_tick && r_us == L_RST_END) ? FINISH : RST;
      end
      SLOT: begin
        busy   = 1'b1;
        w_low  = r_us < (r_tx[0] ? L_LOW1 : L_LOW0);
        w_next = w_last ? FINISH : SLOT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock29M or posedge reset)
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_pre      <= '0;
      r_us       <= '0;
      r_bus      <= 1'b0;
      r_byte     <= 1'b0;
      r_presence <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rxdata   <= '0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= busIn;
      r_sync2 <= r_sync1;
      r_pre   <= (w_accept || w_tick) ? '0 : r_pre + 1'b1;
      if (w_accept) begin
        r_us   <= '0;
        r_bus  <= busSelect;
        r_byte <= cmdType == 2'd2;
        r_tx   <= cmdData;
        r_cnt  <= '0;
      end else if (w_tick) begin
        r_us <= (w_slot_end || !busy) ? '0 : r_us + 1'b1;
        if (r_state == RST && r_us == L_PRES) r_presence <= !w_bus_s;
        // a write-0 slot is held low by us, so force its sample to 0
        if (r_state == SLOT && r_us == L_SAMPLE) r_rx <= {r_tx[0] & w_bus_s, r_rx[7:1]};
        if (w_slot_end) begin
          r_cnt <= r_cnt + 1'b1;
          r_tx  <= {1'b0, r_tx[7:1]};
        end
      end
      if (w_last) r_rxdata <= r_byte ? r_rx : {7'b0, r_rx[7]};
    end
endmodule

// File: tb/tb_onewire_master.sv
`timescale 1ns/1ps
// tb_onewire_master: directed bench with device model, pulse-width and rx scoreboards
module tb_onewire_master;
  localparam int D = 10;
  typedef struct {int lo; int hi;} win_t;
  logic clk = 0, rst = 1, cmd_valid = 0, bus_sel = 0;
  logic [1:0] cmd_type = 0;
  logic [7:0] cmd_data = 0;
  logic [1:0] pull_low, bus_in, dev_low;
  logic busy, done, presence;
  logic [7:0] rx_data;
  int checks = 0, errors = 0, cyc = 0, acc = 0, lat;
  win_t expq[2][$];
  int rises[2][$];
  logic [7:0] exp_rx[$];
  bit rdq[$];
  logic rd_en = 0;
  logic [1:0] dev_present = 2'b01;
  onewire_master #(.US_DIVIDER(D)) dut (
    .clock29M(clk), .reset(rst), .cmdValid(cmd_valid), .cmdType(cmd_type), .cmdData(cmd_data),
    .busSelect(bus_sel), .busIn(bus_in), .pullLow(pull_low), .busy(busy), .done(done),
    .presence(presence), .rxData(rx_data));
  always #17 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus_in = ~(pull_low | dev_low);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask
  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++; $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic pulse_end(input int b, input int w);
    win_t e;
    checks++;
    assert ((expq[b].size() != 0) === 1'b1) else begin
      errors++; $error("FAIL unexpected_pulse bus%0d: observed width %0d expected none", b, w);
    end
    if (expq[b].size() != 0) begin
      e = expq[b].pop_front();
      chk_rng($sformatf("pulse_width bus%0d", b), w, e.lo, e.hi);
    end
  endtask
  // device model: presence pulse 35..150 us after a long low, read-0 holds low 30 us from slot start
  int pt[2], hold[2];
  logic [1:0] pl_prev = 0;
  int lowcnt[2];
  initial begin pt = '{0, 0}; hold = '{0, 0}; lowcnt = '{0, 0}; end
  for (genvar g = 0; g < 2; g++) begin : g_dev
    assign dev_low[g] = (pt[g] >= 35 * D && pt[g] <= 150 * D) || hold[g] != 0;
    always @(posedge clk) begin
      pl_prev[g] <= pull_low[g];
      if (pull_low[g]) lowcnt[g] <= lowcnt[g] + 1;
      else lowcnt[g] <= 0;
      if (pt[g] != 0) pt[g] <= (pt[g] > 150 * D) ? 0 : pt[g] + 1;
      else if (!pull_low[g] && pl_prev[g] && lowcnt[g] >= 400 * D && dev_present[g]) pt[g] <= 1;
      if (g == 0 && pull_low[g] && !pl_prev[g] && rd_en && rdq.size() != 0) hold[g] <= rdq.pop_front() ? 0 : 30 * D;
      else if (hold[g] != 0) hold[g] <= hold[g] - 1;
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int w = 0;
    logic prev = 0;
    always @(negedge clk) begin
      prev <= pull_low[g];
      if (pull_low[g]) begin
        w <= w + 1;
        if (!prev) rises[g].push_back(cyc);
      end else if (w != 0) begin
        w <= 0;
        pulse_end(g, w);
      end
    end
  end
  always @(negedge clk) chk("pull_low_onehot", {31'b0, pull_low === 2'b11}, 0);
  task automatic push_w(input int b, input int lo, input int hi);
    win_t e;
    e.lo = lo; e.hi = hi;
    expq[b].push_back(e);
  endtask
  task automatic issue(input logic [1:0] t, input logic [7:0] d, input logic s);
    @(negedge clk);
    cmd_type = t; cmd_data = d; bus_sel = s; cmd_valid = 1;
    @(negedge clk);
    acc = cyc; cmd_valid = 0;
  endtask
  task automatic wait_done(input int lim, output int l);
    l = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin l = cyc - acc; break; end
    end
  endtask
  task automatic check_slots(input string tag, input int n);
    chk({tag, "_slot_count"}, rises[0].size(), n);
    for (int i = 1; i < rises[0].size(); i++) chk({tag, "_slot_spacing"}, rises[0][i] - rises[0][i-1], 70 * D);
    rises[0].delete();
  endtask
  initial begin
    int dn;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("reset_pull_low", pull_low, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_presence", presence, 0);
    chk("reset_rx", rx_data, 0);
    rst = 0;
    push_w(1, 480 * D, 480 * D);
    issue(2'd0, 8'h00, 1'b1);
    chk("accept_busy", busy, 1);
    wait_done(2000 * D, lat);
    chk_rng("rst_bus1_latency", lat, 961 * D - 1, 961 * D + 1);
    chk("rst_bus1_busy_at_done", busy, 0);
    chk("rst_bus1_presence", presence, 0);
    push_w(0, 480 * D, 480 * D);
    issue(2'd0, 8'h00, 1'b0);
    wait_done(2000 * D, lat);
    chk_rng("rst_bus0_latency", lat, 961 * D - 1, 961 * D + 1);
    chk("rst_bus0_busy_at_done", busy, 0);
    chk("rst_bus0_presence", presence, 1);
    rises[0].delete(); rises[1].delete();
    v = 8'hCC;
    for (int i = 0; i < 8; i++) push_w(0, (v[i] ? 6 : 60) * D, (v[i] ? 6 : 60) * D);
    exp_rx.push_back(8'hCC);
    issue(2'd2, v, 1'b0);
    wait_done(1200 * D, lat);
    chk_rng("write_cc_latency", lat, 560 * D - 8, 560 * D + 8);
    chk("write_cc_rx", rx_data, exp_rx.pop_front());
    chk("write_cc_presence_kept", presence, 1);
    check_slots("write_cc", 8);
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin rdq.push_back(v[i]); push_w(0, 6 * D, 6 * D); end
    exp_rx.push_back(8'hA5);
    rd_en = 1;
    issue(2'd2, 8'hFF, 1'b0);
    wait_done(1200 * D, lat);
    rd_en = 0;
    chk_rng("read_a5_latency", lat, 560 * D - 8, 560 * D + 8);
    chk("read_a5_rx", rx_data, exp_rx.pop_front());
    chk("read_a5_rdq_drained", rdq.size(), 0);
    check_slots("read_a5", 8);
    push_w(0, 6 * D, 6 * D);
    exp_rx.push_back(8'h01);
    issue(2'd1, 8'h01, 1'b0);
    repeat (20 * D) @(negedge clk);
    cmd_type = 2'd2; cmd_data = 8'h00; bus_sel = 1; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("busy_mid_cmd", busy, 1);
    wait_done(200 * D, lat);
    chk_rng("bit1_latency", lat, 70 * D - 1, 70 * D + 1);
    chk("bit1_rx", rx_data, exp_rx.pop_front());
    repeat (100 * D) @(negedge clk);
    check_slots("bit1", 1);
    @(negedge clk);
    cmd_type = 2'd3; cmd_data = 8'h5A; bus_sel = 0; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("type3_busy", busy, 0);
    dn = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); dn += done; end
    chk("type3_no_done", dn, 0);
    chk("type3_rx_kept", rx_data, 8'h01);
    chk("type3_presence_kept", presence, 1);
    check_slots("type3", 0);
    push_w(0, 100 * D, 100 * D + 1);
    issue(2'd0, 8'h00, 1'b0);
    while (cyc < acc + 100 * D) @(negedge clk);
    #5 rst = 1;
    #1;
    chk("abort_pull_low", pull_low, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    #5 rst = 0;
    dn = 0;
    for (int i = 0; i < 1200 * D; i++) begin @(negedge clk); dn += done; end
    chk("abort_no_done", dn, 0);
    chk("abort_presence_cleared", presence, 0);
    rises[0].delete();
    push_w(0, 60 * D, 60 * D);
    exp_rx.push_back(8'h00);
    issue(2'd1, 8'h00, 1'b0);
    wait_done(200 * D, lat);
    chk_rng("bit0_latency", lat, 70 * D - 1, 70 * D + 1);
    chk("bit0_rx", rx_data, exp_rx.pop_front());
    push_w(0, 6 * D, 6 * D);
    exp_rx.push_back(8'h01);
    issue(2'd1, 8'h01, 1'b0);
    wait_done(200 * D, lat);
    chk("bit1b_rx", rx_data, exp_rx.pop_front());
    repeat (10 * D) @(negedge clk);
    chk("bus0_pulses_all_seen", expq[0].size(), 0);
    chk("bus1_pulses_all_seen", expq[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
